ov5640_sccb_wr: RTL and testbench

OV5640_SCCB_WR -- requirements
Module: ov5640_sccb_wr

---
 rtl/ov5640_sccb_wr.sv | 175 +++++++++++++++++
 tb/tb_ov5640_sccb_wr.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_sccb_wr.sv
// SCCB (I2C-style) single-register writer for the OV5640: sends DEVICE_ID, a 16-bit
// register address and an 8-bit value, MSB first, with one ACK slot after every byte.
module ov5640_sccb_wr #(
    parameter logic [7:0] DEVICE_ID = 8'h78,
    parameter int         CLK_DIV   = 25
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_in
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BYTE  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [9:0]  div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        cfg_end_q, cfg_end_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        tick;
    logic [7:0]  cur_byte;

    assign tick = (div_q == 10'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        div_d     = tick ? 10'd0 : div_q + 10'd1;
        qtr_d     = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        data_d    = data_q;
        busy_d    = busy_q;
        cfg_end_d = 1'b0;
        ack_err_d = ack_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                div_d   = 10'd0;
                qtr_d   = 2'd0;
                state_d = S_IDLE;
                // DONE also accepts, which gives back-to-back writes with no idle gap
                if (cfg_start) begin
                    state_d   = S_START;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    data_d    = cfg_data;
                    byte_d    = 2'd0;
                    bit_d     = 4'd7;
                end
            end
            S_START: begin
                if (tick && qtr_q == 2'd3) begin
                    state_d = S_BYTE;
                    byte_d  = 2'd0;
                    bit_d   = 4'd7;
                end
            end
            S_BYTE: begin
                if (tick && qtr_q == 2'd3) begin
                    if (bit_q == 4'd0) state_d = S_ACK;
                    else               bit_d   = bit_q - 4'd1;
                end
            end
            S_ACK: begin
                // sample at the last sys_clk of q1, mid SCL-high
                if (tick && qtr_q == 2'd1 && sda_in) ack_err_d = 1'b1;
                if (tick && qtr_q == 2'd3) begin
                    if (byte_q == 2'd3) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_BYTE;
                        byte_d  = byte_q + 2'd1;
                        bit_d   = 4'd7;
                    end
                end
            end
            S_STOP: begin
                if (tick && qtr_q == 2'd3) begin
                    state_d   = S_DONE;
                    cfg_end_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                div_d   = 10'd0;
                qtr_d   = 2'd0;
            end
        endcase

        case (byte_d)
            2'd0:    cur_byte = DEVICE_ID;
            2'd1:    cur_byte = data_d[23:16];
            2'd2:    cur_byte = data_d[15:8];
            default: cur_byte = data_d[7:0];
        endcase

        // outputs are decoded from the next state so the pins are plain flops
        case (state_d)
            S_START: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = (qtr_d != 2'd0);
            end
            S_BYTE: begin
                scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_oe_d = ~cur_byte[bit_d[2:0]];
            end
            S_ACK: begin
                scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd1);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            div_q     <= 10'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 4'd0;
            byte_q    <= 2'd0;
            data_q    <= 24'd0;
            busy_q    <= 1'b0;
            cfg_end_q <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            cfg_end_q <= cfg_end_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign cfg_end = cfg_end_q;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_ov5640_sccb_wr.sv
// Scoreboard bench for ov5640_sccb_wr: a bus monitor decodes SDA bytes, answers ACK slots,
// checks SCL/SDA timing and pops expected bytes / completion records queued by the stimulus.
`timescale 1ns/1ps
module tb_ov5640_sccb_wr;

    localparam int CLKDIV = 4;
    localparam int TXN_CYC = 152 * CLKDIV + 1;

    logic        sys_clk;
    logic        sys_rst;
    logic        cfg_start;
    logic [23:0] cfg_data;
    logic        cfg_end;
    logic        busy;
    logic        ack_err;
    logic        scl;
    logic        sda_oe;
    logic        sda_in;
    logic        resp_drive;

    assign sda_in = ~(sda_oe | resp_drive);

    ov5640_sccb_wr #(.DEVICE_ID(8'h78), .CLK_DIV(CLKDIV)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg_start(cfg_start),
        .cfg_data (cfg_data),
        .cfg_end  (cfg_end),
        .busy     (busy),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_bytes[$];
    int         exp_end_q[$];
    logic       exp_ack_q[$];

    int   nack_byte = -1;
    int   ends_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- bus monitor / responder / scoreboard ----------------
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       in_txn = 1'b0;
    int         rises = 0;
    int         bib = 0;
    int         byte_idx = 0;
    int         fall_cyc = 0;
    int         rise_cyc = 0;
    logic [7:0] shreg = 8'h00;

    initial resp_drive = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            in_txn     = 1'b0;
            rises      = 0;
            bib        = 0;
            byte_idx   = 0;
            resp_drive = 1'b0;
        end else begin
            if (scl && prev_scl && (sda_in != prev_sda)) begin
                if (!sda_in) begin
                    chk("start_while_idle", {31'd0, in_txn}, 32'd0);
                    in_txn   = 1'b1;
                    rises    = 0;
                    bib      = 0;
                    byte_idx = 0;
                end else begin
                    chk("stop_position", rises, 37);
                    in_txn = 1'b0;
                end
            end
            if (scl && !prev_scl && in_txn) begin
                rises++;
                chk("scl_low_2q", cyc - fall_cyc, 2 * CLKDIV);
                rise_cyc = cyc;
                if (bib < 8) shreg = {shreg[6:0], sda_in};
                bib++;
                if (bib == 8) begin
                    if (exp_bytes.size() > 0) begin
                        chk("sda_byte", {24'd0, shreg}, {24'd0, exp_bytes.pop_front()});
                    end else begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sda_byte: got %0h, required none", shreg);
                    end
                end
            end
            if (!scl && prev_scl && in_txn) begin
                fall_cyc = cyc;
                if (rises >= 1) chk("scl_high_2q", cyc - rise_cyc, 2 * CLKDIV);
                if (bib == 8) begin
                    resp_drive = (byte_idx != nack_byte);
                end else if (bib == 9) begin
                    resp_drive = 1'b0;
                    bib        = 0;
                    byte_idx++;
                end
            end
            if (cfg_end) begin
                ends_seen++;
                if (exp_end_q.size() > 0) begin
                    chk("end_cycle", cyc, exp_end_q.pop_front());
                    chk("ack_err_at_end", {31'd0, ack_err}, {31'd0, exp_ack_q.pop_front()});
                    chk("busy_at_end", {31'd0, busy}, 32'd0);
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cfg_end: got pulse at cycle %0d, required none", cyc);
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda_in;
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [23:0] d, input int nb, input bit want_end, input bit want_ack);
        logic [7:0] b [4];
        b[0] = 8'h78;
        b[1] = d[23:16];
        b[2] = d[15:8];
        b[3] = d[7:0];
        for (int i = 0; i < nb; i++) exp_bytes.push_back(b[i]);
        if (want_end) begin
            exp_end_q.push_back(cyc + TXN_CYC);
            exp_ack_q.push_back(want_ack);
        end
    endtask

    task automatic start_req(input logic [23:0] d, input int nb, input bit want_end, input bit want_ack);
        int k;
        k = 0;
        @(negedge sys_clk);
        while (busy && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        chk("idle_before_req", {31'd0, busy}, 32'd0);
        cfg_start = 1'b1;
        cfg_data  = d;
        push_exp(d, nb, want_end, want_ack);
        @(negedge sys_clk);
        cfg_start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("ack_err_after_accept", {31'd0, ack_err}, 32'd0);
    endtask

    task automatic wait_end();
        int s;
        int k;
        s = ends_seen;
        k = 0;
        while (ends_seen == s && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        chk("end_seen_in_time", {31'd0, (ends_seen != s)}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int k;
        sys_rst   = 1'b1;
        cfg_start = 1'b0;
        cfg_data  = 24'h0;
        repeat (3) @(negedge sys_clk);
        chk("rst_scl", {31'd0, scl}, 32'd1);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cfg_end", {31'd0, cfg_end}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // all bytes acknowledged
        start_req(24'h300842, 4, 1'b1, 1'b0);
        wait_end();

        // NACK on the address-high byte, transaction still runs to completion
        nack_byte = 1;
        start_req(24'h3A1755, 4, 1'b1, 1'b1);
        wait_end();
        nack_byte = -1;

        // second request while busy must be ignored
        start_req(24'h123456, 4, 1'b1, 1'b0);
        repeat (8) @(negedge sys_clk);
        cfg_start = 1'b1;
        cfg_data  = 24'hABCDEF;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        e0 = ends_seen;
        wait_end();
        repeat (30) @(negedge sys_clk);
        chk("single_cfg_end", ends_seen, e0 + 1);

        // back-to-back request issued in the cfg_end cycle
        start_req(24'h5AA5C3, 4, 1'b1, 1'b0);
        k = 0;
        @(negedge sys_clk);
        while (!cfg_end && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        chk("b2b_end_seen", {31'd0, cfg_end}, 32'd1);
        cfg_start = 1'b1;
        cfg_data  = 24'h310303;
        push_exp(24'h310303, 4, 1'b1, 1'b0);
        @(negedge sys_clk);
        cfg_start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_start_scl", {31'd0, scl}, 32'd1);
        wait_end();

        // reset in the middle of the third byte
        start_req(24'h300842, 2, 1'b0, 1'b0);
        repeat (328) @(negedge sys_clk);
        e0 = ends_seen;
        #2;
        sys_rst = 1'b1;
        #1;
        chk("midrst_scl", {31'd0, scl}, 32'd1);
        chk("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cfg_end", {31'd0, cfg_end}, 32'd0);
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("midrst_no_end", ends_seen, e0);
        chk("midrst_bytes_seen", exp_bytes.size(), 0);
        start_req(24'h0A0B0C, 4, 1'b1, 1'b0);
        wait_end();

        repeat (10) @(negedge sys_clk);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("ends_left", exp_end_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
